idex_alu_ctrl: RTL and testbench

ID/EX pipeline register of the pipelined MIPS-Lite CPU with integrated ALU-control decode. It captures decoded operands and control from the ID stage and resolves ALUOp/funct into the per-slice ALU controls (`ctrl`, `Binv`, carry-in) consumed by the 32-slice EX-stage ALU. It supports stall (hold) and flush (bubble insertion) for hazard handling, and flags unsupported R-type functs.

---
 rtl/mips_lite_pkg.sv | 38 +++
 rtl/alu_ctrl_dec.sv | 54 +++++
 rtl/idex_alu_ctrl.sv | 114 +++++++++++
 tb/tb_idex_alu_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lite_pkg.sv
// Shared MIPS-Lite definitions: ALUOp and funct encodings, ALU slice
// result selects, and the bubble value of the EX-stage control bundle.
package mips_lite_pkg;

    // ALUOp encodings driven by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    // Supported R-type funct fields
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Per-slice result select of the 32-slice ALU
    typedef enum logic [2:0] {
        CTRL_AND  = 3'b000,
        CTRL_OR   = 3'b001,
        CTRL_SUM  = 3'b010,
        CTRL_LESS = 3'b011
    } alu_ctrl_e;

    // Control bundle carried from ID into EX
    typedef struct packed {
        logic      valid;
        logic      regwrite;
        alu_ctrl_e ctrl;
        logic      binv;
    } ex_ctl_t;

    // Bubble: no instruction, no write, AND select, no inversion
    localparam ex_ctl_t EX_BUBBLE = '{valid: 1'b0, regwrite: 1'b0,
                                      ctrl: CTRL_AND, binv: 1'b0};

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU-control decoder: resolves ALUOp/funct into the slice result select,
// the B-invert (which doubles as the slice-0 carry-in) and an illegal flag.
// Purely combinational; also used by the single-cycle CPU.
module alu_ctrl_dec
    import mips_lite_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output logic       binv,
    output logic       illegal
);

    // Decode ALUOp first; only R-type consults funct
    always_comb begin
        ctrl    = CTRL_SUM;
        binv    = 1'b0;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: begin
                ctrl = CTRL_SUM;
            end
            ALUOP_SUB: begin
                ctrl = CTRL_SUM;
                binv = 1'b1;
            end
            ALUOP_ORI: begin
                ctrl = CTRL_OR;
            end
            default: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_SUM;
                    FUNCT_SUB: begin
                        ctrl = CTRL_SUM;
                        binv = 1'b1;
                    end
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_SLT: begin
                        // slt subtracts and selects the sign-derived less bit
                        ctrl = CTRL_LESS;
                        binv = 1'b1;
                    end
                    default: begin
                        // Unsupported funct: harmless add, write suppressed at top
                        ctrl    = CTRL_SUM;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/idex_alu_ctrl.sv
// ID/EX pipeline register with integrated ALU-control decode. Captures
// operands and control from ID, supports stall (hold) and flush (bubble),
// and keeps a sticky flag for unsupported R-type functs.
module idex_alu_ctrl
    import mips_lite_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          id_alusrc,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwrite,
    output logic          ex_valid,
    output logic [2:0]    ex_ctrl,
    output logic          ex_binv,
    output logic [DW-1:0] ex_opa,
    output logic [DW-1:0] ex_opb,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_illegal
);

    logic [2:0]    dec_ctrl;
    logic          dec_binv;
    logic          dec_illegal;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] opb_sel;
    ex_ctl_t       ctl_nxt;
    logic          load;

    ex_ctl_t       ctl_p1;
    logic [DW-1:0] opa_p1;
    logic [DW-1:0] opb_p1;
    logic [RW-1:0] rd_p1;
    logic          illegal_p1;

    alu_ctrl_dec u_dec (
        .aluop   (id_aluop),
        .funct   (id_funct),
        .ctrl    (dec_ctrl),
        .binv    (dec_binv),
        .illegal (dec_illegal)
    );

    // Immediate extension (ori zero-extends, all others sign-extend) and B mux
    always_comb begin
        if (id_aluop == ALUOP_ORI) begin
            imm_ext = {{(DW-16){1'b0}}, id_imm};
        end else begin
            imm_ext = {{(DW-16){id_imm[15]}}, id_imm};
        end
        opb_sel = id_alusrc ? imm_ext : id_rt_data;
    end

    // Assemble the control bundle to be loaded on an unstalled edge
    always_comb begin
        ctl_nxt          = EX_BUBBLE;
        ctl_nxt.valid    = id_valid;
        ctl_nxt.regwrite = id_regwrite & id_valid & ~dec_illegal;
        ctl_nxt.ctrl     = alu_ctrl_e'(dec_ctrl);
        ctl_nxt.binv     = dec_binv;
        load             = ~flush & ~stall;
    end

    // ---- ID -> EX boundary ----
    // Pipeline register: flush beats stall, stall holds, else capture ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_p1 <= EX_BUBBLE;
            opa_p1 <= '0;
            opb_p1 <= '0;
            rd_p1  <= '0;
        end else if (flush) begin
            ctl_p1 <= EX_BUBBLE;
            opa_p1 <= '0;
            opb_p1 <= '0;
            rd_p1  <= '0;
        end else if (!stall) begin
            ctl_p1 <= ctl_nxt;
            opa_p1 <= id_rs_data;
            opb_p1 <= opb_sel;
            rd_p1  <= id_rd;
        end
    end

    // Sticky illegal flag: set when a valid unsupported funct is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_p1 <= 1'b0;
        end else if (load && id_valid && dec_illegal) begin
            illegal_p1 <= 1'b1;
        end
    end

    assign ex_valid    = ctl_p1.valid;
    assign ex_regwrite = ctl_p1.regwrite;
    assign ex_ctrl     = ctl_p1.ctrl;
    assign ex_binv     = ctl_p1.binv;
    assign ex_opa      = opa_p1;
    assign ex_opb      = opb_p1;
    assign ex_rd       = rd_p1;
    assign ex_illegal  = illegal_p1;

endmodule

// File: tb/tb_idex_alu_ctrl.sv
// Self-checking bench for idex_alu_ctrl: table-driven decode vectors,
// hand-written stall/flush/illegal/reset sequences, and randomized traffic
// checked against a behavioural model of the ID/EX register.
module tb_idex_alu_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, id_valid, id_alusrc, id_regwrite;
    logic [1:0]    id_aluop;
    logic [5:0]    id_funct;
    logic [DW-1:0] id_rs_data, id_rt_data;
    logic [15:0]   id_imm;
    logic [RW-1:0] id_rd;
    logic          ex_valid, ex_binv, ex_regwrite, ex_illegal;
    logic [2:0]    ex_ctrl;
    logic [DW-1:0] ex_opa, ex_opb;
    logic [RW-1:0] ex_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idex_alu_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_binv(ex_binv),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
    );

    // Behavioural model state
    logic          m_valid, m_binv, m_regwrite, m_illegal;
    logic [2:0]    m_ctrl;
    logic [DW-1:0] m_opa, m_opb;
    logic [RW-1:0] m_rd;

    // Derive ALU behaviour from the instruction's meaning: name the operation,
    // then select the slice output and whether B is negated.
    function automatic void ref_dec(input logic [1:0] aluop, input logic [5:0] funct,
                                    output logic [2:0] ctrl, output logic binv,
                                    output logic ill);
        string op;
        ill = 1'b0;
        if (aluop == 2'd0)      op = "add";
        else if (aluop == 2'd1) op = "sub";
        else if (aluop == 2'd3) op = "or";
        else if (funct == 6'h20) op = "add";
        else if (funct == 6'h22) op = "sub";
        else if (funct == 6'h24) op = "and";
        else if (funct == 6'h25) op = "or";
        else if (funct == 6'h2A) op = "slt";
        else begin
            op  = "add";
            ill = 1'b1;
        end
        ctrl = (op == "and") ? 3'd0 : (op == "or") ? 3'd1 : (op == "slt") ? 3'd3 : 3'd2;
        binv = (op == "sub" || op == "slt");
    endfunction

    function automatic logic [DW-1:0] ref_ext(input logic [1:0] aluop, input logic [15:0] imm);
        int v;
        v = int'(imm);
        if (aluop != 2'd3 && v >= 32768) v = v - 65536;
        return DW'(v);
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_binv = 0; m_regwrite = 0; m_illegal = 0;
        m_ctrl = 0; m_opa = 0; m_opb = 0; m_rd = 0;
    endfunction

    // One clock edge of the model, using the inputs present at that edge
    function automatic void model_edge();
        logic [2:0] c;
        logic b, il;
        ref_dec(id_aluop, id_funct, c, b, il);
        if (flush) begin
            m_valid = 0; m_regwrite = 0; m_ctrl = 0; m_binv = 0;
            m_opa = 0; m_opb = 0; m_rd = 0;
        end else if (!stall) begin
            m_valid    = id_valid;
            m_regwrite = id_regwrite & id_valid & ~il;
            m_ctrl     = c;
            m_binv     = b;
            m_opa      = id_rs_data;
            m_opb      = id_alusrc ? ref_ext(id_aluop, id_imm) : id_rt_data;
            m_rd       = id_rd;
            if (id_valid && il) m_illegal = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},    DW'(ex_valid),    DW'(m_valid));
        check({tag, ".ctrl"},     DW'(ex_ctrl),     DW'(m_ctrl));
        check({tag, ".binv"},     DW'(ex_binv),     DW'(m_binv));
        check({tag, ".opa"},      ex_opa,           m_opa);
        check({tag, ".opb"},      ex_opb,           m_opb);
        check({tag, ".rd"},       DW'(ex_rd),       DW'(m_rd));
        check({tag, ".regwrite"}, DW'(ex_regwrite), DW'(m_regwrite));
        check({tag, ".illegal"},  DW'(ex_illegal),  DW'(m_illegal));
    endtask

    // Advance one clock; the model sees the same inputs as the DUT
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic set_instr(input logic [1:0] aluop, input logic [5:0] funct,
                             input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                             input logic [15:0] imm, input logic alusrc);
        id_valid = 1; id_regwrite = 1; id_aluop = aluop; id_funct = funct;
        id_rs_data = rs; id_rt_data = rt; id_imm = imm; id_alusrc = alusrc;
        id_rd = 5'd9;
    endtask

    typedef struct {
        logic [1:0]    aluop;
        logic [5:0]    funct;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [15:0]   imm;
        logic          alusrc;
        logic [2:0]    exp_ctrl;
        logic          exp_binv;
        logic [DW-1:0] exp_opb;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] legal_f[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        vecs.push_back('{2'b10, 6'h22, 32'd7, 32'd3, 16'h0000, 1'b0, 3'b010, 1'b1, 32'd3});
        vecs.push_back('{2'b10, 6'h2A, 32'd5, 32'd9, 16'h0000, 1'b0, 3'b011, 1'b1, 32'd9});
        vecs.push_back('{2'b11, 6'h00, 32'd1, 32'd2, 16'h8000, 1'b1, 3'b001, 1'b0, 32'h0000_8000});
        vecs.push_back('{2'b00, 6'h00, 32'd4, 32'd2, 16'h8000, 1'b1, 3'b010, 1'b0, 32'hFFFF_8000});
        vecs.push_back('{2'b00, 6'h3F, 32'd4, 32'd2, 16'h7FFF, 1'b1, 3'b010, 1'b0, 32'h0000_7FFF});
        vecs.push_back('{2'b01, 6'h00, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0, 1'b0, 3'b010, 1'b1, 32'h1234_5678});
        vecs.push_back('{2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0, 1'b0, 3'b000, 1'b0, 32'h0FF0_0FF0});
        vecs.push_back('{2'b10, 6'h25, 32'd1, 32'd2, 16'hFFFF, 1'b1, 3'b001, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 6'h20, 32'd11, 32'd22, 16'h0001, 1'b0, 3'b010, 1'b0, 32'd22});

        // Reset state
        rst_n = 0; stall = 0; flush = 0;
        set_instr(2'b00, 6'h0, 32'd0, 32'd0, 16'h0, 1'b0);
        id_valid = 0; id_regwrite = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1;

        // Table-driven decode/extend vectors
        foreach (vecs[i]) begin
            set_instr(vecs[i].aluop, vecs[i].funct, vecs[i].rs, vecs[i].rt,
                      vecs[i].imm, vecs[i].alusrc);
            step();
            check($sformatf("vec%0d.ctrl", i), DW'(ex_ctrl), DW'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d.binv", i), DW'(ex_binv), DW'(vecs[i].exp_binv));
            check($sformatf("vec%0d.opa", i), ex_opa, vecs[i].rs);
            check($sformatf("vec%0d.opb", i), ex_opb, vecs[i].exp_opb);
            check($sformatf("vec%0d.valid", i), DW'(ex_valid), 32'd1);
            check($sformatf("vec%0d.regwrite", i), DW'(ex_regwrite), 32'd1);
        end

        // Stall hold: load and, stall 3 cycles while ID shows or
        set_instr(2'b10, 6'h24, 32'd1, 32'd2, 16'h0, 1'b0);
        step();
        check("stall.load", DW'(ex_ctrl), 32'd0);
        set_instr(2'b10, 6'h25, 32'd5, 32'd6, 16'h0, 1'b0);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall.hold%0d.ctrl", k), DW'(ex_ctrl), 32'd0);
            check($sformatf("stall.hold%0d.opa", k), ex_opa, 32'd1);
        end
        stall = 0;
        step();
        check("stall.release.ctrl", DW'(ex_ctrl), 32'd1);
        check("stall.release.opa", ex_opa, 32'd5);

        // Stall and flush together: bubble
        stall = 1; flush = 1;
        step();
        check("flushstall.valid", DW'(ex_valid), 32'd0);
        check("flushstall.regwrite", DW'(ex_regwrite), 32'd0);
        check("flushstall.ctrl", DW'(ex_ctrl), 32'd0);
        check("flushstall.opa", ex_opa, 32'd0);
        check("flushstall.opb", ex_opb, 32'd0);
        stall = 0; flush = 0;

        // id_valid low: operands captured, valid/regwrite low
        set_instr(2'b10, 6'h22, 32'd77, 32'd88, 16'h0, 1'b0);
        id_valid = 0;
        step();
        check("novalid.valid", DW'(ex_valid), 32'd0);
        check("novalid.regwrite", DW'(ex_regwrite), 32'd0);
        check("novalid.opa", ex_opa, 32'd77);
        check("novalid.binv", DW'(ex_binv), 32'd1);
        check("novalid.illegal", DW'(ex_illegal), 32'd0);

        // Illegal funct: regwrite suppressed, sticky across flush, cleared by reset
        set_instr(2'b10, 6'h3F, 32'd1, 32'd2, 16'h0, 1'b0);
        step();
        check("illegal.regwrite", DW'(ex_regwrite), 32'd0);
        check("illegal.valid", DW'(ex_valid), 32'd1);
        check("illegal.flag", DW'(ex_illegal), 32'd1);
        set_instr(2'b10, 6'h20, 32'd1, 32'd2, 16'h0, 1'b0);
        flush = 1;
        step();
        check("illegal.afterflush", DW'(ex_illegal), 32'd1);
        check("illegal.flushvalid", DW'(ex_valid), 32'd0);
        flush = 0;
        step();
        check("illegal.sticky", DW'(ex_illegal), 32'd1);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("illegal.cleared", DW'(ex_illegal), 32'd0);
        rst_n = 1;

        // Asynchronous reset between edges while EX holds a valid add
        set_instr(2'b10, 6'h20, 32'd123, 32'd456, 16'h0, 1'b0);
        step();
        check_model("preasync");
        #2 rst_n = 0;
        model_reset();
        #1;
        check_model("async");
        step();
        rst_n = 1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_regwrite = $urandom_range(0, 1);
            id_aluop    = 2'($urandom_range(0, 3));
            id_funct    = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 4)];
            id_rs_data  = $urandom;
            id_rt_data  = $urandom;
            id_imm      = 16'($urandom);
            id_alusrc   = $urandom_range(0, 1);
            id_rd       = 5'($urandom);
            step();
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
